// File: rtl/regfile_pkg.sv
// Shared defaults, address type and popcount helper for the multi-port register file.
package regfile_pkg;

    localparam int unsigned WIDTH_DEF  = 32;
    localparam int unsigned NREG_DEF   = 32;
    localparam int unsigned NRD_DEF    = 2;
    localparam int unsigned ADDR_W_DEF = $clog2(NREG_DEF);
    localparam int unsigned POP_MAX    = 1024;

    typedef logic [ADDR_W_DEF-1:0] addr_t;

    // Callers zero-extend their vector to POP_MAX bits.
    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < POP_MAX; i++) begin
            cnt = cnt + int'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: writes clear, issues set (set wins), registered busy count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned ADDR_W = $clog2(NREG),
    parameter int unsigned CNT_W  = $clog2(NREG + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [NREG-1:0]   busy,
    output logic [CNT_W-1:0]  busy_cnt
);

    logic [NREG-1:0]    r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [NREG-1:0]    w_busy_nxt;
    logic [POP_MAX-1:0] w_busy_ext;

    always_comb begin
        w_busy_nxt = r_busy;
        if (we0 && (wa0 != '0)) w_busy_nxt[wa0] = 1'b0;
        if (we1 && (wa1 != '0)) w_busy_nxt[wa1] = 1'b0;
        // Issue applied last: a new producer supersedes a retiring one.
        if (iss_en && (iss_addr != '0)) w_busy_nxt[iss_addr] = 1'b1;
    end

    assign w_busy_ext = POP_MAX'(w_busy_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= CNT_W'(popcount(w_busy_ext));
        end
    end

    assign busy     = r_busy;
    assign busy_cnt = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads, two prioritised writes, busy scoreboard.
// Optional write-to-read forwarding enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned ADDR_W = $clog2(NREG),
    parameter int unsigned NRD    = NRD_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0]     rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [WIDTH-1:0]         wd0,
    input  logic [WIDTH-1:0]         wd1,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [$clog2(NREG+1)-1:0] busy_cnt
);

    localparam int unsigned CNT_W = $clog2(NREG + 1);

    logic [WIDTH-1:0] r_mem [NREG];
    logic [NREG-1:0]  w_busy;
    logic             w_wr0;
    logic             w_wr1;

    assign w_wr0 = we0 && (wa0 != '0);
    assign w_wr1 = we1 && (wa1 != '0) && !(we0 && (wa0 == wa1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr1) r_mem[wa1] <= wd1;
            if (w_wr0) r_mem[wa0] <= wd0;
        end
    end

    regfile_scoreboard #(
        .NREG   (NREG),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .we0      (we0),
        .wa0      (wa0),
        .we1      (we1),
        .wa1      (wa1),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy     (w_busy),
        .busy_cnt (busy_cnt)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [WIDTH-1:0]  w_arr;
        logic              w_abusy;

        assign w_ra    = rd_addr[k*ADDR_W +: ADDR_W];
        assign w_arr   = r_mem[w_ra];
        assign w_abusy = w_busy[w_ra];

`ifdef REGFILE_BYPASS_EN
        logic w_hit0;
        logic w_hit1;
        logic w_iss_hit;

        assign w_hit0    = we0 && (wa0 == w_ra) && (w_ra != '0);
        assign w_hit1    = we1 && (wa1 == w_ra) && (w_ra != '0);
        assign w_iss_hit = iss_en && (iss_addr == w_ra);

        always_comb begin
            rd_data[k*WIDTH +: WIDTH] = w_arr;
            rd_busy[k]                = w_abusy;
            if (w_hit0) begin
                rd_data[k*WIDTH +: WIDTH] = wd0;
            end else if (w_hit1) begin
                rd_data[k*WIDTH +: WIDTH] = wd1;
            end
            if ((w_hit0 || w_hit1) && !w_iss_hit) begin
                rd_busy[k] = 1'b0;
            end
        end
`else
        assign rd_data[k*WIDTH +: WIDTH] = w_arr;
        assign rd_busy[k]                = w_abusy;
`endif
    end

endmodule
